// File: rtl/store_lane_queue.sv
// Store-path queue: accepts sized stores, queues them, and emits big-endian
// lane-aligned memory beats, splitting or rejecting misaligned stores.
module store_lane_queue #(
  parameter int DATA_W           = 32,
  parameter int ADDR_W           = 32,
  parameter int DEPTH            = 2,
  parameter int SPLIT_MISALIGNED = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_size,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_data,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_we,
  output logic                req_err
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {FIRST, SECOND} state_t;

  // Queue storage: the raw request is kept; lanes are derived from the head.
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [1:0]        size_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  state_t           state, state_next;

  logic [3:0] req_n;
  logic       req_illegal, req_misaligned, req_accept, req_bad, push, pop;

  logic [ADDR_W-1:0]   head_addr, base_addr;
  logic [1:0]          head_size;
  logic [DATA_W-1:0]   head_data, data_mask;
  logic [OFF_W-1:0]    head_off;
  logic [3:0]          head_n;
  logic [2*DATA_W-1:0] lane_data;
  logic [2*NB-1:0]     lane_we;
  logic                has_beat2;
  int                  shift_bytes;

  assign req_ready  = (count < CNT_W'(DEPTH));
  assign mem_valid  = (count != '0);
  assign req_accept = req_valid && req_ready;

  // Classify the incoming request: illegal size, misalignment, enqueue decision.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
    req_n          = 4'(1) << req_size;
    req_illegal    = int'(req_n) > NB;
    req_misaligned = (4'(req_addr[OFF_W-1:0]) & (req_n - 4'd1)) != 4'd0;
    req_bad        = req_illegal || (req_misaligned && SPLIT_MISALIGNED == 0);
    push           = req_accept && !req_bad;
  end

  assign head_addr = addr_q[rd_ptr];
  assign head_size = size_q[rd_ptr];
  assign head_data = data_q[rd_ptr];
  assign head_off  = head_addr[OFF_W-1:0];
  assign base_addr = {head_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  // Place the head store into a two-beat big-endian lane vector.
  always_comb begin
    head_n      = 4'(1) << head_size;
    data_mask   = '0;
    lane_we     = '0;
    for (int i = 0; i < NB; i++) begin
      if (i < int'(head_n)) begin
        data_mask[i*8 +: 8] = 8'hFF;
        lane_we[i]          = 1'b1;
      end
    end
    shift_bytes = 2 * NB - int'(head_off) - int'(head_n);
    lane_data   = '0;
    lane_data[DATA_W-1:0] = head_data & data_mask;
    lane_data   = lane_data << (8 * shift_bytes);
    lane_we     = lane_we << shift_bytes;
    has_beat2   = (int'(head_off) + int'(head_n)) > NB;
  end

  // Beat sequencing on the queue head and memory-side outputs.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_we     = '0;
    if (mem_valid) begin
      case (state)
        FIRST: begin
          mem_addr  = base_addr;
          mem_wdata = lane_data[2*DATA_W-1:DATA_W];
          mem_we    = lane_we[2*NB-1:NB];
          if (mem_ready) begin
            if (has_beat2) state_next = SECOND;
            else           pop        = 1'b1;
          end
        end
        SECOND: begin
          mem_addr  = base_addr + ADDR_W'(NB);
          mem_wdata = lane_data[DATA_W-1:0];
          mem_we    = lane_we[NB-1:0];
          if (mem_ready) begin
            pop        = 1'b1;
            state_next = FIRST;
          end
        end
        default: state_next = FIRST;
      endcase
    end
  end

  // FSM state, pointers, occupancy and the registered error pulse.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state   <= FIRST;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      req_err <= 1'b0;
    end else begin
      state   <= state_next;
      req_err <= req_accept && req_bad;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue payload write.
  always_ff @(posedge clk) begin
    // NOTE: payload storage is not reset; empty entries are never presented because outputs are gated by count.
    if (push) begin
      addr_q[wr_ptr] <= req_addr;
      size_q[wr_ptr] <= req_size;
      data_q[wr_ptr] <= req_data;
    end
  end

endmodule

// File: tb/tb_store_lane_queue.sv
// Self-checking bench for store_lane_queue: a split instance checked by a
// byte-level reference model, and a rejecting instance checked directly.
module tb_store_lane_queue;

  localparam int NB = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;

  logic        req_valid, req_ready, mem_valid, mem_ready, req_err;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_data, mem_addr, mem_wdata;
  logic [3:0]  mem_we;

  logic        b_req_valid, b_req_ready, b_mem_valid, b_mem_ready, b_req_err;
  logic [1:0]  b_req_size;
  logic [31:0] b_req_addr, b_req_data, b_mem_addr, b_mem_wdata;
  logic [3:0]  b_mem_we;

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t beat_q[$];
  int    ent_q[$];
  logic  exp_err = 1'b0;

  store_lane_queue #(.DATA_W(32), .ADDR_W(32), .DEPTH(2), .SPLIT_MISALIGNED(1)) dut_split (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_size(req_size),
    .req_addr(req_addr), .req_data(req_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .req_err(req_err)
  );

  store_lane_queue #(.DATA_W(32), .ADDR_W(32), .DEPTH(2), .SPLIT_MISALIGNED(0)) dut_reject (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_size(b_req_size),
    .req_addr(b_req_addr), .req_data(b_req_data),
    .mem_valid(b_mem_valid), .mem_ready(b_mem_ready), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_we(b_mem_we), .req_err(b_req_err)
  );

  always #5 clk = ~clk;

  // Reference model: walk the store bytes one by one into memory lanes.
  task automatic model_accept(input logic [1:0] sz, input logic [31:0] a,
                              input logic [31:0] d, output logic err);
    int    n, off, p;
    beat_t b[2];
    n   = 1 << sz;
    off = int'(a % NB);
    err = 1'b0;
    if (n > NB) begin
      err = 1'b1;
      return;
    end
    for (int k = 0; k < 2; k++) begin
      b[k].addr  = (a & ~32'(NB - 1)) + 32'(k * NB);
      b[k].wdata = '0;
      b[k].we    = '0;
    end
    for (int j = 0; j < n; j++) begin
      p = off + j;
      b[p / NB].wdata[(NB - 1 - (p % NB)) * 8 +: 8] = d[(n - 1 - j) * 8 +: 8];
      b[p / NB].we[NB - 1 - (p % NB)] = 1'b1;
    end
    beat_q.push_back(b[0]);
    if (b[1].we != 0) begin
      beat_q.push_back(b[1]);
      ent_q.push_back(2);
    end else begin
      ent_q.push_back(1);
    end
  endtask

  // One clock of the split instance: drive, compare against the model, advance it.
  task automatic step(input logic v, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] d, input logic mr);
    logic  exp_ready, exp_valid, err;
    beat_t eb;
    @(negedge clk);
    req_valid = v; req_size = sz; req_addr = a; req_data = d; mem_ready = mr;
    #1;
    exp_ready = ent_q.size() < 2;
    exp_valid = ent_q.size() != 0;
    n_checks++;
    if (req_ready !== exp_ready) begin
      n_fail++; $display("FAIL req_ready: got %b expected %b", req_ready, exp_ready);
    end
    n_checks++;
    if (mem_valid !== exp_valid) begin
      n_fail++; $display("FAIL mem_valid: got %b expected %b", mem_valid, exp_valid);
    end
    n_checks++;
    if (req_err !== exp_err) begin
      n_fail++; $display("FAIL req_err: got %b expected %b", req_err, exp_err);
    end
    if (exp_valid) begin
      eb = beat_q[0];
    end else begin
      eb.addr = '0; eb.wdata = '0; eb.we = '0;
    end
    n_checks++;
    if (mem_addr !== eb.addr || mem_wdata !== eb.wdata || mem_we !== eb.we) begin
      n_fail++;
      $display("FAIL beat: got addr %h wdata %h we %b expected addr %h wdata %h we %b",
               mem_addr, mem_wdata, mem_we, eb.addr, eb.wdata, eb.we);
    end
    if (v && exp_ready) begin
      model_accept(sz, a, d, err);
      exp_err = err;
    end else begin
      exp_err = 1'b0;
    end
    if (exp_valid && mr) begin
      void'(beat_q.pop_front());
      ent_q[0]--;
      if (ent_q[0] == 0) void'(ent_q.pop_front());
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 0; req_size = 0; req_addr = 0; req_data = 0; mem_ready = 0;
    b_req_valid = 0; b_req_size = 0; b_req_addr = 0; b_req_data = 0; b_mem_ready = 0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || mem_valid !== 1'b0 || req_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got ready %b valid %b err %b expected 1 0 0",
                         req_ready, mem_valid, req_err);
    end
    n_checks++;
    if (mem_addr !== 0 || mem_wdata !== 0 || mem_we !== 0) begin
      n_fail++; $display("FAIL reset_data: got %h %h %b expected zeros", mem_addr, mem_wdata, mem_we);
    end
    rst = 1'b0;
  endtask

  task automatic test_byte_half();
    step(1'b1, 2'd0, 32'h1001, 32'h000000AB, 1'b1);
    step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
    n_checks++;
    if (mem_valid !== 1'b1 || mem_addr !== 32'h1000 || mem_we !== 4'b0100 || mem_wdata !== 32'h00AB0000) begin
      n_fail++; $display("FAIL sb: got v %b addr %h we %b wdata %h expected 1 00001000 0100 00ab0000",
                         mem_valid, mem_addr, mem_we, mem_wdata);
    end
    step(1'b1, 2'd1, 32'h2002, 32'h00001234, 1'b1);
    step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
    n_checks++;
    if (mem_valid !== 1'b1 || mem_addr !== 32'h2000 || mem_we !== 4'b0011 || mem_wdata !== 32'h00001234) begin
      n_fail++; $display("FAIL sh: got v %b addr %h we %b wdata %h expected 1 00002000 0011 00001234",
                         mem_valid, mem_addr, mem_we, mem_wdata);
    end
    idle(2);
  endtask

  task automatic test_split();
    step(1'b1, 2'd2, 32'h3003, 32'hDEADBEEF, 1'b1);
    step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
    n_checks++;
    if (mem_addr !== 32'h3000 || mem_we !== 4'b0001 || mem_wdata !== 32'h000000DE) begin
      n_fail++; $display("FAIL split_b1: got addr %h we %b wdata %h expected 00003000 0001 000000de",
                         mem_addr, mem_we, mem_wdata);
    end
    step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
    n_checks++;
    if (mem_valid !== 1'b1 || mem_addr !== 32'h3004 || mem_we !== 4'b1110 || mem_wdata !== 32'hADBEEF00) begin
      n_fail++; $display("FAIL split_b2: got v %b addr %h we %b wdata %h expected 1 00003004 1110 adbeef00",
                         mem_valid, mem_addr, mem_we, mem_wdata);
    end
    step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
    n_checks++;
    if (mem_valid !== 1'b0) begin
      n_fail++; $display("FAIL split_pop: got mem_valid %b expected 0", mem_valid);
    end
  endtask

  task automatic test_backpressure();
    step(1'b1, 2'd2, 32'h0, 32'h11111111, 1'b0);
    step(1'b1, 2'd2, 32'h4, 32'h22222222, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'd2, 32'h8, 32'h33333333, 1'b0);
      n_checks++;
      if (req_ready !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h11111111) begin
        n_fail++; $display("FAIL stall: got ready %b addr %h wdata %h expected 0 00000000 11111111",
                           req_ready, mem_addr, mem_wdata);
      end
    end
    step(1'b1, 2'd2, 32'h8, 32'h33333333, 1'b1);
    n_checks++;
    if (req_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_pop_ready: got %b expected 0", req_ready);
    end
    step(1'b1, 2'd2, 32'h8, 32'h33333333, 1'b1);
    n_checks++;
    if (req_ready !== 1'b1 || mem_addr !== 32'h4) begin
      n_fail++; $display("FAIL release: got ready %b addr %h expected 1 00000004", req_ready, mem_addr);
    end
    step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
    n_checks++;
    if (mem_addr !== 32'h8 || mem_wdata !== 32'h33333333) begin
      n_fail++; $display("FAIL order: got addr %h wdata %h expected 00000008 33333333", mem_addr, mem_wdata);
    end
    idle(2);
  endtask

  task automatic test_reset_mid_split();
    step(1'b1, 2'd2, 32'h3003, 32'hDEADBEEF, 1'b1);
    step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    #1;
    n_checks++;
    if (mem_we !== 4'b1110) begin
      n_fail++; $display("FAIL pre_rst_second: got we %b expected 1110", mem_we);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (mem_valid !== 1'b0 || req_ready !== 1'b1 || mem_addr !== 0 || mem_wdata !== 0 || mem_we !== 0) begin
      n_fail++; $display("FAIL mid_rst: got v %b ready %b addr %h wdata %h we %b expected 0 1 zeros",
                         mem_valid, req_ready, mem_addr, mem_wdata, mem_we);
    end
    beat_q.delete();
    ent_q.delete();
    exp_err = 1'b0;
    #1 rst = 1'b0;
    step(1'b1, 2'd0, 32'h1001, 32'h000000AB, 1'b1);
    step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
    n_checks++;
    if (mem_addr !== 32'h1000 || mem_we !== 4'b0100 || mem_wdata !== 32'h00AB0000) begin
      n_fail++; $display("FAIL post_rst: got addr %h we %b wdata %h expected 00001000 0100 00ab0000",
                         mem_addr, mem_we, mem_wdata);
    end
    idle(2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom,
           1'($urandom_range(0, 3) != 0));
    end
    idle(6);
  endtask

  task automatic test_reject();
    @(negedge clk);
    b_req_valid = 1; b_req_size = 2'd2; b_req_addr = 32'h3003; b_req_data = 32'hDEADBEEF; b_mem_ready = 1;
    #1;
    n_checks++;
    if (b_req_ready !== 1'b1 || b_req_err !== 1'b0) begin
      n_fail++; $display("FAIL rej_accept: got ready %b err %b expected 1 0", b_req_ready, b_req_err);
    end
    @(negedge clk);
    b_req_size = 2'd3; b_req_addr = 32'h0;
    #1;
    n_checks++;
    if (b_req_err !== 1'b1 || b_mem_valid !== 1'b0) begin
      n_fail++; $display("FAIL rej_err1: got err %b valid %b expected 1 0", b_req_err, b_mem_valid);
    end
    @(negedge clk);
    b_req_valid = 0;
    #1;
    n_checks++;
    if (b_req_err !== 1'b1 || b_mem_valid !== 1'b0) begin
      n_fail++; $display("FAIL rej_err2: got err %b valid %b expected 1 0", b_req_err, b_mem_valid);
    end
    @(negedge clk);
    b_req_valid = 1; b_req_size = 2'd2; b_req_addr = 32'h10; b_req_data = 32'h12345678;
    #1;
    n_checks++;
    if (b_req_err !== 1'b0 || b_mem_valid !== 1'b0) begin
      n_fail++; $display("FAIL rej_quiet: got err %b valid %b expected 0 0", b_req_err, b_mem_valid);
    end
    @(negedge clk);
    b_req_valid = 0;
    #1;
    n_checks++;
    if (b_mem_valid !== 1'b1 || b_mem_addr !== 32'h10 || b_mem_wdata !== 32'h12345678 || b_mem_we !== 4'b1111) begin
      n_fail++; $display("FAIL rej_aligned: got v %b addr %h wdata %h we %b expected 1 00000010 12345678 1111",
                         b_mem_valid, b_mem_addr, b_mem_wdata, b_mem_we);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (b_mem_valid !== 1'b0) begin
      n_fail++; $display("FAIL rej_drain: got valid %b expected 0", b_mem_valid);
    end
  endtask

  initial begin
    test_reset();
    test_byte_half();
    test_split();
    test_backpressure();
    test_reject();
    test_reset_mid_split();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
